stack_alu_engine: RTL and testbench

//  Parametrised stack-machine ALU. On a start pulse it pops one or two operands from the

---
 rtl/stack_alu_pkg.sv | 35 +++
 rtl/stack_alu_exec.sv | 58 +++++
 rtl/stack_alu_engine.sv | 177 +++++++++++++++++
 tb/tb_stack_alu_engine.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/stack_alu_pkg.sv
// Shared opcode encoding, FSM state encoding and opcode classification
// for the stack-machine ALU.
package stack_alu_pkg;

    localparam int OPCODE_W = 3;

    localparam logic [OPCODE_W-1:0] OP_ADD = 3'd0;
    localparam logic [OPCODE_W-1:0] OP_SUB = 3'd1;
    localparam logic [OPCODE_W-1:0] OP_AND = 3'd2;
    localparam logic [OPCODE_W-1:0] OP_OR  = 3'd3;
    localparam logic [OPCODE_W-1:0] OP_XOR = 3'd4;
    localparam logic [OPCODE_W-1:0] OP_NEG = 3'd5;
    localparam logic [OPCODE_W-1:0] OP_NOT = 3'd6;
    localparam logic [OPCODE_W-1:0] OP_DUP = 3'd7;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_POP_A = 4'd1,
        ST_RCV_A = 4'd2,
        ST_POP_B = 4'd3,
        ST_RCV_B = 4'd4,
        ST_EXEC  = 4'd5,
        ST_PUSH  = 4'd6,
        ST_PUSH2 = 4'd7,
        ST_DONE  = 4'd8
    } state_t;

    function automatic logic is_unary(input logic [OPCODE_W-1:0] opc);
        case (opc)
            OP_NEG, OP_NOT, OP_DUP: is_unary = 1'b1;
            default:                is_unary = 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/stack_alu_exec.sv
// Combinational ALU datapath: result plus carry/borrow and signed overflow.
// Operand a is the old top of stack, b the entry below it.
module stack_alu_exec
    import stack_alu_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic [DATA_W-1:0]   op_a,
    input  logic [DATA_W-1:0]   op_b,
    input  logic [OPCODE_W-1:0] opcode,
    output logic [DATA_W-1:0]   res,
    output logic                c,
    output logic                v
);

    localparam logic [DATA_W-1:0] MOST_NEG = {1'b1, {(DATA_W-1){1'b0}}};

    logic [DATA_W:0] sum_s;
    logic [DATA_W:0] dif_s;
    logic [DATA_W:0] neg_s;

    // The extra top bit is the carry for add and the borrow for sub/neg.
    assign sum_s = {1'b0, op_a} + {1'b0, op_b};
    assign dif_s = {1'b0, op_a} - {1'b0, op_b};
    assign neg_s = {(DATA_W+1){1'b0}} - {1'b0, op_a};

    // Operation select; DUP passes op_a through unchanged.
    always_comb begin
        res = op_a;
        c   = 1'b0;
        v   = 1'b0;
        case (opcode)
            OP_ADD: begin
                res = sum_s[DATA_W-1:0];
                c   = sum_s[DATA_W];
                v   = (op_a[DATA_W-1] == op_b[DATA_W-1]) && (sum_s[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_SUB: begin
                res = dif_s[DATA_W-1:0];
                c   = dif_s[DATA_W];
                v   = (op_a[DATA_W-1] != op_b[DATA_W-1]) && (dif_s[DATA_W-1] != op_a[DATA_W-1]);
            end
            OP_AND: res = op_a & op_b;
            OP_OR:  res = op_a | op_b;
            OP_XOR: res = op_a ^ op_b;
            OP_NEG: begin
                // Borrow of 0 - a, i.e. set for any non-zero operand.
                res = neg_s[DATA_W-1:0];
                c   = neg_s[DATA_W];
                v   = (op_a == MOST_NEG);
            end
            OP_NOT: res = ~op_a;
            OP_DUP: res = op_a;
            default: res = op_a;
        endcase
    end

endmodule

// File: rtl/stack_alu_engine.sv
// Stack-machine ALU engine: pops one or two operands from an external stack,
// runs one of eight operations, pushes the result and keeps Z/S/C/V flags.
module stack_alu_engine
    import stack_alu_pkg::*;
#(
    parameter int DATA_W = 8,
    parameter int OPC_W  = OPCODE_W
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              start,
    input  logic [OPC_W-1:0]  opcode,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              z,
    output logic              s,
    output logic              c,
    output logic              v,
    output logic              stk_pop,
    output logic              stk_push,
    output logic [DATA_W-1:0] stk_wdata,
    input  logic [DATA_W-1:0] stk_rdata,
    input  logic              stk_empty,
    input  logic              stk_full
);

    state_t             state_r;
    state_t             state_nx_s;
    logic               err_set_s;
    logic               flag_upd_s;

    logic [OPC_W-1:0]   opc_r;
    logic [DATA_W-1:0]  op_a_r;
    logic [DATA_W-1:0]  op_b_r;
    logic [DATA_W-1:0]  res_r;
    logic               nz_r, ns_r, nc_r, nv_r;
    logic               z_r, s_r, c_r, v_r;
    logic               busy_r, done_r, err_r;

    logic [DATA_W-1:0]  exe_res_s;
    logic               exe_c_s;
    logic               exe_v_s;

    stack_alu_exec #(.DATA_W(DATA_W)) u_exec (
        .op_a   (op_a_r),
        .op_b   (op_b_r),
        .opcode (opc_r),
        .res    (exe_res_s),
        .c      (exe_c_s),
        .v      (exe_v_s)
    );

    // FSM state register.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next-state logic; stack status is checked in the same cycle as the strobe.
    always_comb begin
        state_nx_s = state_r;
        err_set_s  = 1'b0;
        flag_upd_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) state_nx_s = ST_POP_A;
                else       state_nx_s = ST_IDLE;
            end
            ST_POP_A: begin
                if (stk_empty) begin
                    state_nx_s = ST_DONE;
                    err_set_s  = 1'b1;
                end else begin
                    state_nx_s = ST_RCV_A;
                end
            end
            ST_RCV_A: begin
                if (is_unary(opc_r)) state_nx_s = ST_EXEC;
                else                 state_nx_s = ST_POP_B;
            end
            ST_POP_B: begin
                if (stk_empty) begin
                    state_nx_s = ST_DONE;
                    err_set_s  = 1'b1;
                end else begin
                    state_nx_s = ST_RCV_B;
                end
            end
            ST_RCV_B: state_nx_s = ST_EXEC;
            ST_EXEC:  state_nx_s = ST_PUSH;
            ST_PUSH: begin
                if (stk_full) begin
                    state_nx_s = ST_DONE;
                    err_set_s  = 1'b1;
                end else if (opc_r == OP_DUP) begin
                    state_nx_s = ST_PUSH2;
                end else begin
                    state_nx_s = ST_DONE;
                    flag_upd_s = 1'b1;
                end
            end
            ST_PUSH2: begin
                state_nx_s = ST_DONE;
                if (stk_full) err_set_s = 1'b1;
                else          err_set_s = 1'b0;
            end
            ST_DONE: state_nx_s = ST_IDLE;
            default: state_nx_s = ST_IDLE;
        endcase
    end

    // Operand capture, result and pending-flag registers.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            opc_r  <= {OPC_W{1'b0}};
            op_a_r <= {DATA_W{1'b0}};
            op_b_r <= {DATA_W{1'b0}};
            res_r  <= {DATA_W{1'b0}};
            nz_r   <= 1'b0;
            ns_r   <= 1'b0;
            nc_r   <= 1'b0;
            nv_r   <= 1'b0;
        end else begin
            if (state_r == ST_IDLE && start) opc_r <= opcode;
            if (state_r == ST_RCV_A) op_a_r <= stk_rdata;
            if (state_r == ST_RCV_B) op_b_r <= stk_rdata;
            if (state_r == ST_EXEC) begin
                res_r <= exe_res_s;
                nz_r  <= (exe_res_s == {DATA_W{1'b0}});
                ns_r  <= exe_res_s[DATA_W-1];
                nc_r  <= exe_c_s;
                nv_r  <= exe_v_s;
            end
        end
    end

    // Status and flag outputs; flags commit only once the push is accepted.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
            err_r  <= 1'b0;
            z_r    <= 1'b0;
            s_r    <= 1'b0;
            c_r    <= 1'b0;
            v_r    <= 1'b0;
        end else begin
            busy_r <= (state_nx_s != ST_IDLE) && (state_nx_s != ST_DONE);
            done_r <= (state_nx_s == ST_DONE);
            if (state_r == ST_IDLE && start) err_r <= 1'b0;
            else if (err_set_s)              err_r <= 1'b1;
            if (flag_upd_s) begin
                z_r <= nz_r;
                s_r <= ns_r;
                c_r <= nc_r;
                v_r <= nv_r;
            end
        end
    end

    assign busy      = busy_r;
    assign done      = done_r;
    assign err       = err_r;
    assign z         = z_r;
    assign s         = s_r;
    assign c         = c_r;
    assign v         = v_r;
    assign stk_wdata = res_r;
    // Strobes follow the state directly so pop/push happen in the POP/PUSH cycle.
    assign stk_pop   = ((state_r == ST_POP_A) || (state_r == ST_POP_B)) && !stk_empty;
    assign stk_push  = ((state_r == ST_PUSH) || (state_r == ST_PUSH2)) && !stk_full;

endmodule

// File: tb/tb_stack_alu_engine.sv
// Bench for stack_alu_engine: a small external stack, a queue-based reference
// model, and a scoreboard monitor that checks every push and every done.
module tb_stack_alu_engine;

    localparam int DEPTH = 4;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       start = 1'b0;
    logic [2:0] opcode = 3'd0;
    logic       busy, done, err, z, s, c, v, stk_pop, stk_push;
    logic [7:0] stk_wdata;
    logic [7:0] stk_rdata = 8'h00;
    logic       stk_empty, stk_full;
    logic       force_full = 1'b0;

    stack_alu_engine #(.DATA_W(8), .OPC_W(3)) dut (
        .clk(clk), .rstn(rstn), .start(start), .opcode(opcode),
        .busy(busy), .done(done), .err(err), .z(z), .s(s), .c(c), .v(v),
        .stk_pop(stk_pop), .stk_push(stk_push), .stk_wdata(stk_wdata),
        .stk_rdata(stk_rdata), .stk_empty(stk_empty), .stk_full(stk_full)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // External operand stack (index 0 = bottom), 1-cycle read latency.
    logic [7:0] mem [0:DEPTH-1];
    logic [7:0] ld_vals [0:DEPTH-1];
    int         ld_n = 0;
    logic       ld_en = 1'b0;
    int         env_cnt = 0;

    always @(posedge clk) begin
        if (ld_en) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= ld_vals[i];
            env_cnt <= ld_n;
        end else if (stk_pop && env_cnt > 0) begin
            stk_rdata <= mem[env_cnt-1];
            env_cnt   <= env_cnt - 1;
        end else if (stk_push && env_cnt < DEPTH) begin
            mem[env_cnt] <= stk_wdata;
            env_cnt      <= env_cnt + 1;
        end
    end
    assign stk_empty = (env_cnt == 0);
    assign stk_full  = (env_cnt >= DEPTH) || force_full;

    // Reference model state.
    int   model_q[$];
    logic mz = 1'b0, ms = 1'b0, mc = 1'b0, mv = 1'b0, merr = 1'b0;

    typedef struct {
        logic err, z, s, c, v;
        int   lat, t0, n_pop, pop_base;
    } exp_t;
    exp_t       exp_q[$];
    logic [7:0] push_q[$];
    exp_t       me;

    int n_checks = 0, n_pass = 0, tot_pop = 0, done_cnt = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, want, $time);
    endtask

    task automatic fail_now(input string name);
        n_checks++;
        $display("FAIL %s (t=%0t)", name, $time);
    endtask

    // Scoreboard monitor, sampling on the falling edge.
    always @(negedge clk) begin
        if (rstn) begin
            if (stk_pop) tot_pop++;
            if (stk_push) begin
                check("push_pop_excl", stk_pop, 0);
                if (push_q.size() == 0) fail_now("unexpected_push");
                else check("push_data", stk_wdata, push_q.pop_front());
            end
            if (done) begin
                done_cnt++;
                if (exp_q.size() == 0) fail_now("unexpected_done");
                else begin
                    me = exp_q.pop_front();
                    check("err", err, me.err);
                    check("flag_z", z, me.z);
                    check("flag_s", s, me.s);
                    check("flag_c", c, me.c);
                    check("flag_v", v, me.v);
                    check("latency", cyc - me.t0, me.lat);
                    check("pop_count", tot_pop - me.pop_base, me.n_pop);
                    check("pushes_left", push_q.size(), 0);
                end
            end
        end
    end

    function automatic bit m_full();
        return force_full || (model_q.size() >= DEPTH);
    endfunction

    function automatic int sgn(input int x);
        return (x >= 128) ? x - 256 : x;
    endfunction

    // Load the stack; arguments are listed top first.
    task automatic load(input int n, input int t0, input int t1, input int t2, input int t3);
        int tv[4];
        tv = '{t0, t1, t2, t3};
        @(negedge clk);
        ld_n = n;
        model_q.delete();
        for (int i = 0; i < n; i++) ld_vals[n-1-i] = tv[i][7:0];
        for (int i = 0; i < n; i++) model_q.push_back(int'(ld_vals[i]));
        ld_en = 1'b1;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic run_op(input logic [2:0] opc, input bit spur);
        exp_t e;
        int   a = 0, b = 0, r = 0, d_base, ss;
        bit   ok = 1'b1, nc = 1'b0, nv = 1'b0, got = 1'b0;
        e.lat = 0; e.n_pop = 0;
        if (model_q.size() == 0) begin
            ok = 1'b0; e.lat = 2;
        end else begin
            a = model_q.pop_back(); e.n_pop = 1;
            if (opc < 3'd5) begin
                if (model_q.size() == 0) begin ok = 1'b0; e.lat = 4; end
                else begin b = model_q.pop_back(); e.n_pop = 2; end
            end
        end
        if (ok) begin
            case (opc)
                3'd0: begin r = (a + b) & 255; nc = (a + b) > 255;
                            ss = sgn(a) + sgn(b); nv = (ss > 127) || (ss < -128); end
                3'd1: begin r = (a - b) & 255; nc = (a < b);
                            ss = sgn(a) - sgn(b); nv = (ss > 127) || (ss < -128); end
                3'd2: r = a & b;
                3'd3: r = a | b;
                3'd4: r = a ^ b;
                3'd5: begin r = (0 - a) & 255; nc = (a != 0); nv = (a == 128); end
                3'd6: r = (~a) & 255;
                default: r = a;
            endcase
            if (opc == 3'd7) begin
                if (m_full()) begin ok = 1'b0; e.lat = 5; end
                else begin
                    push_q.push_back(a[7:0]); model_q.push_back(a); e.lat = 6;
                    if (m_full()) ok = 1'b0;
                    else begin push_q.push_back(a[7:0]); model_q.push_back(a); end
                end
            end else begin
                e.lat = (opc < 3'd5) ? 7 : 5;
                if (m_full()) ok = 1'b0;
                else begin
                    push_q.push_back(r[7:0]); model_q.push_back(r);
                    mz = (r == 0); ms = (r >= 128); mc = nc; mv = nv;
                end
            end
        end
        merr = !ok;
        e.err = merr; e.z = mz; e.s = ms; e.c = mc; e.v = mv;
        d_base = done_cnt;
        @(negedge clk);
        e.t0 = cyc; e.pop_base = tot_pop;
        exp_q.push_back(e);
        opcode = opc; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        if (spur) begin
            @(negedge clk);
            start = 1'b1; opcode = 3'($urandom_range(0, 7));
            @(negedge clk);
            start = 1'b0;
        end
        for (int k = 0; k < 40; k++) begin
            if (done_cnt > d_base) begin got = 1'b1; break; end
            @(posedge clk);
        end
        if (!got) begin
            fail_now("done_timeout");
            exp_q.delete(); push_q.delete();
        end
        @(negedge clk);
        check("err_hold", err, merr);
        check("stack_depth", env_cnt, model_q.size());
    endtask

    function automatic int pick_val();
        case ($urandom_range(0, 5))
            0: return 8'h00;
            1: return 8'h7F;
            2: return 8'h80;
            3: return 8'hFF;
            default: return $urandom_range(0, 255);
        endcase
    endfunction

    initial begin
        repeat (3) @(posedge clk);
        #1 check("rst_outputs", {busy, done, err, z, s, c, v, stk_pop, stk_push, stk_wdata}, 0);
        @(negedge clk) rstn = 1'b1;

        // Abort in RCV_A: one operand is lost, nothing is pushed.
        load(2, 3, 5, 0, 0);
        @(negedge clk); opcode = 3'd0; start = 1'b1;
        @(negedge clk); start = 1'b0;
        check("busy_after_start", busy, 1);
        @(negedge clk); rstn = 1'b0;
        #1 check("abort_outputs", {busy, done, err, z, s, c, v, stk_pop, stk_push, stk_wdata}, 0);
        void'(model_q.pop_back());
        @(negedge clk); rstn = 1'b1;
        check("abort_depth", env_cnt, model_q.size());

        load(2, 3, 5, 0, 0);          run_op(3'd0, 1'b0);   // 3+5=8
        load(2, 8'h7F, 8'h01, 0, 0);  run_op(3'd0, 1'b0);   // 0x80, v=1
        load(2, 8'h01, 8'h02, 0, 0);  run_op(3'd1, 1'b0);   // 0xFF, c=1
        load(2, 8'h05, 8'h05, 0, 0);  run_op(3'd1, 1'b0);   // z=1
        load(1, 8'h80, 0, 0, 0);      run_op(3'd5, 1'b0);   // NEG most negative
        load(1, 8'h0F, 0, 0, 0);      run_op(3'd6, 1'b0);   // NOT
        load(1, 8'hA5, 0, 0, 0);      run_op(3'd7, 1'b0);   // DUP, flags kept
        load(4, 8'hA5, 1, 2, 3);      run_op(3'd7, 1'b0);   // DUP, one free slot
        load(1, 8'h33, 0, 0, 0);      run_op(3'd4, 1'b0);   // underflow at B
        load(0, 0, 0, 0, 0);          run_op(3'd4, 1'b0);   // underflow at A
        force_full = 1'b1;
        load(2, 3, 5, 0, 0);          run_op(3'd0, 1'b0);   // overflow
        force_full = 1'b0;
        load(2, 9, 4, 0, 0);          run_op(3'd1, 1'b1);   // start while busy
        load(0, 0, 0, 0, 0);          run_op(3'd0, 1'b1);   // start during DONE

        for (int t = 0; t < 40; t++) begin
            force_full = ($urandom_range(0, 9) == 0);
            load($urandom_range(0, DEPTH), pick_val(), pick_val(), pick_val(), pick_val());
            run_op(3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        force_full = 1'b0;

        repeat (3) @(negedge clk);
        check("exp_queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
